// File: rtl/wbuf_pkg.sv
// Shared widths, FSM state encoding and line-address helper for the
// dcache victim write buffer.
package wbuf_pkg;

  localparam int LINE_W   = 256;
  localparam int ADDR_W   = 32;
  localparam int OFFSET_W = 5;
  localparam int TAG_W    = ADDR_W - OFFSET_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MEM_WR = 2'd1,
    ST_MEM_RD = 2'd2,
    ST_ACK    = 2'd3
  } wbuf_state_e;

  // A line is identified by the address bits above the byte offset.
  function automatic logic [TAG_W-1:0] line_of(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:OFFSET_W];
  endfunction

endpackage

// File: rtl/wbuf_fifo.sv
// Victim-line storage for dcache_wbuf: circular queue of DEPTH entries
// (line address, 256-bit data, valid) with a line-address CAM.
// A write whose line hits a valid entry overwrites it in place; otherwise
// it is appended at the tail. Pop always removes the oldest entry.
// The hit data port exists only when WBUF_FWD_EN is defined.
module wbuf_fifo
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [TAG_W-1:0]      lookup_line_i,
  input  logic                  wr_en_i,
  input  logic [LINE_W-1:0]     wr_data_i,
  input  logic                  pop_i,
  output logic                  hit_o,
`ifdef WBUF_FWD_EN
  output logic [LINE_W-1:0]     hit_data_o,
`endif
  output logic [TAG_W-1:0]      head_line_o,
  output logic [LINE_W-1:0]     head_data_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0]  valid_q;
  logic [TAG_W-1:0]  line_q [DEPTH];
  logic [LINE_W-1:0] data_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q, hit_idx, wr_idx;
  logic [PTR_W:0]    count_q;
  logic              push;

  // CAM: at most one valid entry can hold a given line, so no priority needed.
  always_comb begin
    hit_o   = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && (line_q[i] == lookup_line_i)) begin
        hit_o   = 1'b1;
        hit_idx = PTR_W'(i);
      end
    end
  end

  assign push   = wr_en_i && !hit_o;
  assign wr_idx = hit_o ? hit_idx : wr_ptr_q;

  // Valid bits, pointers and occupancy count.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        valid_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q          <= wr_ptr_q + PTR_W'(1);
      end
      if (pop_i) begin
        valid_q[rd_ptr_q] <= 1'b0;
        rd_ptr_q          <= rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry payload; qualified by valid_q, so it needs no reset.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      line_q[wr_idx] <= lookup_line_i;
      data_q[wr_idx] <= wr_data_i;
    end
  end

`ifdef WBUF_FWD_EN
  assign hit_data_o = data_q[hit_idx];
`endif
  assign head_line_o = line_q[rd_ptr_q];
  assign head_data_o = data_q[rd_ptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/dcache_wbuf.sv
// dcache victim write buffer: sits between the dcache controller and data
// memory, absorbing line write-backs and draining them when the CPU side
// is idle. Reads bypass pending drains when WBUF_FWD_EN is defined
// (matching reads are forwarded from the buffer); without it, a read first
// drains the whole buffer and then goes to memory.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// ST_IDLE   | accept CPU request, or start a drain when CPU is quiet
// ST_MEM_WR | writing oldest entry to memory, pop on mem_ack_i
// ST_MEM_RD | reading a line from memory, latch data on mem_ack_i
// ST_ACK    | one-cycle cpu_ack_o; next IDLE cycle ignores cpu_enable_i
module dcache_wbuf
  import wbuf_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [LINE_W-1:0] cpu_data_i,
  input  logic              cpu_enable_i,
  input  logic              cpu_write_i,
  output logic [LINE_W-1:0] cpu_data_o,
  output logic              cpu_ack_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [LINE_W-1:0] mem_data_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  wbuf_state_e       state_q, state_d;
  logic              turn_q;
  logic [TAG_W-1:0]  req_line, rd_line_q, head_line;
  logic [LINE_W-1:0] head_data, cpu_data_q;
  logic [CNT_W-1:0]  buf_count;
  logic              buf_empty, buf_full, hit;
  logic              fifo_wr, fifo_pop, ld_rd;
`ifdef WBUF_FWD_EN
  logic [LINE_W-1:0] hit_data;
  logic              fwd_ld;
`endif

  assign req_line  = line_of(cpu_addr_i);
  assign buf_empty = (buf_count == '0);
  assign buf_full  = (buf_count == CNT_W'(DEPTH));

  wbuf_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .lookup_line_i (req_line),
    .wr_en_i       (fifo_wr),
    .wr_data_i     (cpu_data_i),
    .pop_i         (fifo_pop),
    .hit_o         (hit),
`ifdef WBUF_FWD_EN
    .hit_data_o    (hit_data),
`endif
    .head_line_o   (head_line),
    .head_data_o   (head_data),
    .count_o       (buf_count)
  );

  // State register plus turnaround flag for the cycle after ACK.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      turn_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      turn_q  <= (state_q == ST_ACK);
    end
  end

  // Next state and buffer/latch strobes.
  always_comb begin
    state_d  = state_q;
    fifo_wr  = 1'b0;
    fifo_pop = 1'b0;
    ld_rd    = 1'b0;
`ifdef WBUF_FWD_EN
    fwd_ld   = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        // During turnaround nothing starts, so a held request cannot be
        // taken twice and back-to-back writes are not split by a drain.
        if (!turn_q) begin
          if (cpu_enable_i && cpu_write_i) begin
            if (hit || !buf_full) begin
              fifo_wr = 1'b1;
              state_d = ST_ACK;
            end else begin
              state_d = ST_MEM_WR;
            end
          end else if (cpu_enable_i) begin
`ifdef WBUF_FWD_EN
            if (hit) begin
              fwd_ld  = 1'b1;
              state_d = ST_ACK;
            end else begin
              ld_rd   = 1'b1;
              state_d = ST_MEM_RD;
            end
`else
            if (!buf_empty) begin
              state_d = ST_MEM_WR;
            end else begin
              ld_rd   = 1'b1;
              state_d = ST_MEM_RD;
            end
`endif
          end else if (!buf_empty) begin
            state_d = ST_MEM_WR;
          end
        end
      end
      ST_MEM_WR: begin
        if (mem_ack_i) begin
          fifo_pop = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      ST_MEM_RD: begin
        if (mem_ack_i) state_d = ST_ACK;
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Line address of the outstanding memory read.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)     rd_line_q <= '0;
    else if (ld_rd) rd_line_q <= req_line;
  end

  // Read return register; holds until the next read response.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cpu_data_q <= '0;
    end else if ((state_q == ST_MEM_RD) && mem_ack_i) begin
      cpu_data_q <= mem_data_i;
`ifdef WBUF_FWD_EN
    end else if (fwd_ld) begin
      cpu_data_q <= hit_data;
`endif
    end
  end

  // Downstream request is a pure function of state, so it stays stable
  // through the ack cycle and reads as zero whenever no access is active.
  always_comb begin
    mem_addr_o = '0;
    mem_data_o = '0;
    case (state_q)
      ST_MEM_WR: begin
        mem_addr_o = {head_line, {OFFSET_W{1'b0}}};
        mem_data_o = head_data;
      end
      ST_MEM_RD: mem_addr_o = {rd_line_q, {OFFSET_W{1'b0}}};
      default:   mem_addr_o = '0;
    endcase
  end

  assign mem_enable_o = (state_q == ST_MEM_WR) || (state_q == ST_MEM_RD);
  assign mem_write_o  = (state_q == ST_MEM_WR);
  assign cpu_ack_o    = (state_q == ST_ACK);
  assign cpu_data_o   = cpu_data_q;

endmodule

// File: tb/tb_dcache_wbuf.sv
// Self-checking bench for dcache_wbuf. The reference model is a coherent
// memory view: a read must return the last data written to that line, and
// once the buffer is empty, memory must hold exactly that data.
module tb_dcache_wbuf;

  localparam int DEPTH = 2;
`ifdef WBUF_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  localparam logic [255:0] INIT_PAT =
    256'h0000111122223333444455556666777788889999AAAABBBBCCCCDDDDEEEEFFFF;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [31:0]  cpu_addr_i;
  logic [255:0] cpu_data_i;
  logic         cpu_enable_i, cpu_write_i;
  logic [255:0] cpu_data_o;
  logic         cpu_ack_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic         mem_enable_o, mem_write_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  dcache_wbuf #(.DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_data_i   (cpu_data_i),
    .cpu_enable_i (cpu_enable_i),
    .cpu_write_i  (cpu_write_i),
    .cpu_data_o   (cpu_data_o),
    .cpu_ack_o    (cpu_ack_o),
    .mem_addr_o   (mem_addr_o),
    .mem_data_o   (mem_data_o),
    .mem_enable_o (mem_enable_o),
    .mem_write_o  (mem_write_o),
    .mem_data_i   (mem_data_i),
    .mem_ack_i    (mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int n_err = 0;
  int n_checks = 0;
  int mem_delay = 0;

  logic [255:0] mem_img [int];
  logic [255:0] gold [int];
  bit           log_wr [$];
  int           log_line [$];
  logic [255:0] log_data [$];

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] init_line(input int line);
    return INIT_PAT ^ {8{line}};
  endfunction

  function automatic logic [255:0] mem_value(input int line);
    if (mem_img.exists(line)) return mem_img[line];
    return init_line(line);
  endfunction

  function automatic logic [255:0] expect_rd(input int line);
    if (gold.exists(line)) return gold[line];
    return mem_value(line);
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom();
    return r;
  endfunction

  // Memory responder: ack after mem_delay cycles, track stability.
  bit           busy = 1'b0;
  int           left = 0;
  logic [31:0]  t_addr;
  logic [255:0] t_data;
  logic         t_wr;

  initial begin
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_i) begin
        busy      = 1'b0;
        mem_ack_i = 1'b0;
      end else if (mem_ack_i) begin
        mem_ack_i = 1'b0;
        check("mem_enable_drop", 256'(mem_enable_o), 256'(0));
      end else if (mem_enable_o) begin
        if (!busy) begin
          busy   = 1'b1;
          left   = mem_delay;
          t_addr = mem_addr_o;
          t_data = mem_data_o;
          t_wr   = mem_write_o;
        end else begin
          check("mem_addr_hold", 256'(mem_addr_o), 256'(t_addr));
          check("mem_data_hold", mem_data_o, t_data);
          check("mem_write_hold", 256'(mem_write_o), 256'(t_wr));
        end
        if (left == 0) begin
          busy = 1'b0;
          mem_ack_i = 1'b1;
          log_wr.push_back(t_wr);
          log_line.push_back(int'(t_addr[31:5]));
          log_data.push_back(t_data);
          if (t_wr) mem_img[int'(t_addr[31:5])] = t_data;
          else      mem_data_i = mem_value(int'(t_addr[31:5]));
        end else begin
          left--;
        end
      end
    end
  end

  // Issue one CPU request (called at a negedge); hold until ack.
  task automatic cpu_op(input string tag, input bit wr, input logic [31:0] addr,
                        input logic [255:0] data, output logic [255:0] rdata);
    bit ok = 1'b0;
    cpu_enable_i = 1'b1;
    cpu_write_i  = wr;
    cpu_addr_i   = addr;
    cpu_data_i   = data;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_i);
      if (cpu_ack_o) begin
        ok = 1'b1;
        break;
      end
    end
    rdata = cpu_data_o;
    cpu_enable_i = 1'b0;
    if (wr) gold[int'(addr[31:5])] = data;
    check({tag, "_ack"}, 256'(ok), 256'(1));
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk_i);
      if (dut.buf_count == 0 && !mem_enable_o && !mem_ack_i) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, 256'(ok), 256'(1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] rd, d;
    int s, delta;
    bit ok;

    rst_i = 1'b0;
    cpu_enable_i = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i = '0;
    cpu_data_i = '0;
    repeat (3) @(negedge clk_i);
    check("rst_ack", 256'(cpu_ack_o), 256'(0));
    check("rst_men", 256'(mem_enable_o), 256'(0));
    check("rst_mwr", 256'(mem_write_o), 256'(0));
    check("rst_maddr", 256'(mem_addr_o), 256'(0));
    check("rst_mdata", mem_data_o, 256'(0));
    check("rst_cdata", cpu_data_o, 256'(0));
    check("rst_count", 256'(dut.buf_count), 256'(0));
    rst_i = 1'b1;
    @(negedge clk_i);

    // Single write, ack in cycle 2, then drain to memory line 32.
    mem_delay = 2;
    s = log_wr.size();
    cpu_enable_i = 1'b1; cpu_write_i = 1'b1;
    cpu_addr_i = 32'h0000_0400; cpu_data_i = {32{8'hA5}};
    @(negedge clk_i);
    check("wr_ack_cycle2", 256'(cpu_ack_o), 256'(1));
    check("wr_count1", 256'(dut.buf_count), 256'(1));
    cpu_enable_i = 1'b0;
    gold[32] = {32{8'hA5}};
    @(negedge clk_i);
    check("wr_ack_one_cycle", 256'(cpu_ack_o), 256'(0));
    wait_idle("drain_400_idle");
    check("drain_400_txns", 256'(log_wr.size() - s), 256'(1));
    check("drain_400_line", 256'((log_line.size() > s) ? log_line[s] : -1), 256'(32));
    check("mem32", mem_value(32), {32{8'hA5}});

    // Full buffer: the third write waits for the oldest drain.
    mem_delay = 6;
    s = log_wr.size();
    cpu_op("fill_200", 1'b1, 32'h200, rand256(), rd);
    cpu_op("fill_220", 1'b1, 32'h220, rand256(), rd);
    cpu_op("fill_240", 1'b1, 32'h240, rand256(), rd);
    check("full_wait_txns", 256'(log_wr.size() - s), 256'(1));
    check("full_wait_line", 256'((log_line.size() > s) ? log_line[s] : -1), 256'(16));
    check("full_count", 256'(dut.buf_count), 256'(2));
    wait_idle("full_idle");

    // Same-line writes coalesce into one entry.
    mem_delay = 1;
    s = log_wr.size();
    d = rand256();
    cpu_op("coal_x", 1'b1, 32'h200, rand256(), rd);
    cpu_op("coal_y", 1'b1, 32'h210, d, rd);
    check("coal_count", 256'(dut.buf_count), 256'(1));
    wait_idle("coal_idle");
    check("coal_txns", 256'(log_wr.size() - s), 256'(1));
    check("coal_data", (log_data.size() > s) ? log_data[s] : '0, d);

    // Write then read the same line: forwarded or drain-then-read.
    d = rand256();
    cpu_op("fw_wr", 1'b1, 32'h40, d, rd);
    s = log_wr.size();
    cpu_op("fw_rd", 1'b0, 32'h40, '0, rd);
    delta = log_wr.size() - s;
    check("fw_rdata", rd, d);
    check("fw_txns", 256'(delta), 256'(FWD ? 0 : 2));
    check("fw_order", 256'((delta >= 2) ? {log_wr[s], log_wr[s+1]} : 2'b00),
          256'(FWD ? 2'b00 : 2'b10));
    wait_idle("fw_idle");

    // Miss read with one pending entry.
    mem_delay = 2;
    cpu_op("miss_wr", 1'b1, 32'h400, rand256(), rd);
    s = log_wr.size();
    cpu_op("miss_rd", 1'b0, 32'h0, '0, rd);
    check("miss_rdata", rd, INIT_PAT);
    wait_idle("miss_idle");
    check("miss_txns", 256'(log_wr.size() - s), 256'(2));
    check("miss_first_wr", 256'((log_wr.size() > s) ? log_wr[s] : 1'bx), 256'(!FWD));
    check("miss_first_line", 256'((log_line.size() > s) ? log_line[s] : -1), 256'(FWD ? 0 : 32));

    // Reset during a drain discards buffered data.
    mem_delay = 20;
    cpu_op("rst_wr", 1'b1, 32'h600, rand256(), rd);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (mem_enable_o && mem_write_o) begin
        ok = 1'b1;
        break;
      end
    end
    check("rst_drain_started", 256'(ok), 256'(1));
    rst_i = 1'b0;
    #1;
    check("rst_mid_men", 256'(mem_enable_o), 256'(0));
    check("rst_mid_mwr", 256'(mem_write_o), 256'(0));
    check("rst_mid_maddr", 256'(mem_addr_o), 256'(0));
    check("rst_mid_count", 256'(dut.buf_count), 256'(0));
    check("rst_mid_cdata", cpu_data_o, 256'(0));
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    gold.delete();
    mem_delay = 1;
    @(negedge clk_i);
    cpu_op("post_rst_rd", 1'b0, 32'h600, '0, rd);
    check("post_rst_rdata", rd, mem_value(48));

    // Randomized traffic over a small set of lines.
    for (int n = 0; n < 300; n++) begin
      int li;
      int line;
      logic [31:0] addr;
      logic [255:0] exp;
      li   = int'($urandom_range(0, 5));
      line = (li < 4) ? 16 + li : 32 + li;
      addr = {line[26:0], 5'($urandom())};
      mem_delay = int'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        cpu_op("rand_wr", 1'b1, addr, rand256(), rd);
      end else begin
        exp = expect_rd(line);
        cpu_op("rand_rd", 1'b0, addr, '0, rd);
        check("rand_rdata", rd, exp);
      end
      check("rand_count_le_depth", 256'(dut.buf_count <= DEPTH), 256'(1));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end
    wait_idle("rand_idle");
    for (int li = 0; li < 6; li++) begin
      int line;
      line = (li < 4) ? 16 + li : 32 + li;
      check("final_mem", mem_value(line), expect_rd(line));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
